// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if
//   Bundles the stage-register fields the hazard unit observes and the
//   stall/flush/forward controls it returns to the 5-stage datapath.
//   Modports:
//     master - datapath side: drives stage fields, receives controls
//     slave  - hazard unit side: receives stage fields, drives controls
//   Fields:
//     Rs1D, Rs2D            source registers of the instruction in D
//     Rs1E, Rs2E, RdE       source/destination registers in E
//     RegWriteE             E instruction writes RdE
//     ResultSrcE0           E instruction is a load
//     MultiCycleE           E instruction is a multi-cycle MUL/DIV
//     PCSrcE                taken branch/jump resolved in E
//     RdM, RegWriteM        M-stage destination and write enable
//     RdW, RegWriteW        W-stage destination and write enable
//     StallF/D/E            hold stage registers
//     FlushD/E/M            clear stage registers (bubble)
//     ForwardAE/BE          00 regfile, 01 W result, 10 M ALU result
//     BusyE                 multi-cycle interlock active
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;
  logic              ResultSrcE0;
  logic              MultiCycleE;
  logic              PCSrcE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              BusyE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE0,
           MultiCycleE, PCSrcE, RdM, RegWriteM, RdW, RegWriteW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, BusyE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE0,
           MultiCycleE, PCSrcE, RdM, RegWriteM, RdW, RegWriteW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, BusyE
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard unit for a 5-stage RISC-V pipeline with optional M/W->E
//   forwarding and a multi-cycle execute interlock. While a MUL/DIV
//   occupies E for MC_LATENCY cycles, F/D/E are held and bubbles are
//   pushed into M.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; forces every output to 0
//     hz   hazard_unit_mc_if.slave - stage fields in, controls out
//   Parameters:
//     REG_AW      register address width (x0 = address 0)
//     FORWARD_EN  1 = forward from M/W, 0 = resolve RAW by stalling in D
//     MC_LATENCY  cycles a multi-cycle op occupies E (1..16)
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1,
  parameter int MC_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_mc_if.slave hz
);

  localparam int CNT_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  // The entry cycle in IDLE already counts as the first occupied cycle,
  // and the final cnt==0 cycle releases, so BUSY starts MC_LATENCY-2 away.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       data_stall;
  logic       data_stall_fwd;
  logic       data_stall_nofwd;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m;
  logic       busy_e;

  // Register r is read by the instruction in D (x0 never conflicts).
  function automatic logic hit_d(input logic [REG_AW-1:0] r,
                                 input logic [REG_AW-1:0] rs1,
                                 input logic [REG_AW-1:0] rs2);
    return (r != '0) && ((r == rs1) || (r == rs2));
  endfunction

  // Forward select for one E source operand; M is younger so it wins.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (rs == '0)                    return 2'b00;
    else if (we_m && (rd_m == rs))   return 2'b10;
    else if (we_w && (rd_w == rs))   return 2'b01;
    else                             return 2'b00;
  endfunction

  always_comb begin
    // Without forwarding, any in-flight writer in E or M to a D source
    // must drain first; W is safe because the register file is write-first.
    data_stall_fwd   = hz.ResultSrcE0 && hit_d(hz.RdE, hz.Rs1D, hz.Rs2D);
    data_stall_nofwd = (hz.RegWriteE && hit_d(hz.RdE, hz.Rs1D, hz.Rs2D)) ||
                       (hz.RegWriteM && hit_d(hz.RdM, hz.Rs1D, hz.Rs2D));
    data_stall       = (FORWARD_EN != 0) ? data_stall_fwd : data_stall_nofwd;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    busy_e  = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;

    if (FORWARD_EN != 0) begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    end

    case (state_q)
      IDLE: begin
        if (hz.PCSrcE) begin
          // Redirect kills the multi-cycle op before it starts.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (hz.MultiCycleE && (MC_LATENCY > 1)) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          busy_e  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end else if (data_stall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          busy_e  = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          // Last occupied cycle: op leaves E now, so ordinary D-stage
          // hazards against it apply again.
          state_d = IDLE;
          if (data_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      busy_e  = 1'b0;
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushM    = flush_m;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.BusyE     = busy_e;

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic          regwe, lde, mce, pcse, regwm, regww;

  int total;
  int passed;

  hazard_unit_mc_if #(.REG_AW(AW)) if_fw ();
  hazard_unit_mc_if #(.REG_AW(AW)) if_nf ();
  hazard_unit_mc_if #(.REG_AW(AW)) if_l1 ();

  hazard_unit_mc #(.REG_AW(AW), .FORWARD_EN(1), .MC_LATENCY(4))
    dut_fw (.clk(clk), .rst(rst), .hz(if_fw.slave));
  hazard_unit_mc #(.REG_AW(AW), .FORWARD_EN(0), .MC_LATENCY(4))
    dut_nf (.clk(clk), .rst(rst), .hz(if_nf.slave));
  hazard_unit_mc #(.REG_AW(AW), .FORWARD_EN(1), .MC_LATENCY(1))
    dut_l1 (.clk(clk), .rst(rst), .hz(if_l1.slave));

  assign if_fw.Rs1D = rs1d;  assign if_nf.Rs1D = rs1d;  assign if_l1.Rs1D = rs1d;
  assign if_fw.Rs2D = rs2d;  assign if_nf.Rs2D = rs2d;  assign if_l1.Rs2D = rs2d;
  assign if_fw.Rs1E = rs1e;  assign if_nf.Rs1E = rs1e;  assign if_l1.Rs1E = rs1e;
  assign if_fw.Rs2E = rs2e;  assign if_nf.Rs2E = rs2e;  assign if_l1.Rs2E = rs2e;
  assign if_fw.RdE  = rde;   assign if_nf.RdE  = rde;   assign if_l1.RdE  = rde;
  assign if_fw.RdM  = rdm;   assign if_nf.RdM  = rdm;   assign if_l1.RdM  = rdm;
  assign if_fw.RdW  = rdw;   assign if_nf.RdW  = rdw;   assign if_l1.RdW  = rdw;
  assign if_fw.RegWriteE   = regwe;  assign if_nf.RegWriteE   = regwe;  assign if_l1.RegWriteE   = regwe;
  assign if_fw.ResultSrcE0 = lde;    assign if_nf.ResultSrcE0 = lde;    assign if_l1.ResultSrcE0 = lde;
  assign if_fw.MultiCycleE = mce;    assign if_nf.MultiCycleE = mce;    assign if_l1.MultiCycleE = mce;
  assign if_fw.PCSrcE      = pcse;   assign if_nf.PCSrcE      = pcse;   assign if_l1.PCSrcE      = pcse;
  assign if_fw.RegWriteM   = regwm;  assign if_nf.RegWriteM   = regwm;  assign if_l1.RegWriteM   = regwm;
  assign if_fw.RegWriteW   = regww;  assign if_nf.RegWriteW   = regww;  assign if_l1.RegWriteW   = regww;

  // Packed view: {BusyE, StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE}
  wire [10:0] o_fw = {if_fw.BusyE, if_fw.StallF, if_fw.StallD, if_fw.StallE,
                      if_fw.FlushD, if_fw.FlushE, if_fw.FlushM,
                      if_fw.ForwardAE, if_fw.ForwardBE};
  wire [10:0] o_nf = {if_nf.BusyE, if_nf.StallF, if_nf.StallD, if_nf.StallE,
                      if_nf.FlushD, if_nf.FlushE, if_nf.FlushM,
                      if_nf.ForwardAE, if_nf.ForwardBE};
  wire [10:0] o_l1 = {if_l1.BusyE, if_l1.StallF, if_l1.StallD, if_l1.StallE,
                      if_l1.FlushD, if_l1.FlushE, if_l1.FlushM,
                      if_l1.ForwardAE, if_l1.ForwardBE};
  // {BusyE, StallF, StallD, StallE, FlushM} of the FORWARD_EN=1 unit
  wire [4:0]  mc_fw = {if_fw.BusyE, if_fw.StallF, if_fw.StallD, if_fw.StallE, if_fw.FlushM};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] exp_o(input logic busy, input logic sf, input logic sd,
                                        input logic se, input logic fd, input logic fe,
                                        input logic fm, input logic [1:0] fa,
                                        input logic [1:0] fb);
    return {busy, sf, sd, se, fd, fe, fm, fa, fb};
  endfunction

  task automatic clear_inputs();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
    regwe = 1'b0; lde = 1'b0; mce = 1'b0; pcse = 1'b0; regwm = 1'b0; regww = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    cyc();
    rst = 1'b1;
    mce = 1'b1; regwm = 1'b1; rdm = 5'd5; rs1e = 5'd5;
    lde = 1'b1; rde = 5'd7; rs1d = 5'd7;
    #1;
    e = '0;
    total++; if (o_fw !== e) $display("FAIL reset_fw: got %b expected %b", o_fw, e); else passed++;
    total++; if (o_nf !== e) $display("FAIL reset_nf: got %b expected %b", o_nf, e); else passed++;
    cyc();
    rst = 1'b0;
    clear_inputs();
    #1;
    total++; if (o_fw !== e) $display("FAIL reset_release_idle: got %b expected %b", o_fw, e); else passed++;
  endtask

  task automatic test_forwarding();
    logic [10:0] e;
    cyc();
    clear_inputs();
    rs1e = 5'd5; rdm = 5'd5; regwm = 1'b1; rdw = 5'd5; regww = 1'b1;
    #1;
    e = exp_o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00);
    total++; if (o_fw !== e) $display("FAIL fwd_m_priority: got %b expected %b", o_fw, e); else passed++;
    total++; if (if_nf.ForwardAE !== 2'b00) $display("FAIL fwd_disabled_a: got %b expected 00", if_nf.ForwardAE); else passed++;
    regwm = 1'b0;
    #1;
    e = exp_o(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00);
    total++; if (o_fw !== e) $display("FAIL fwd_w: got %b expected %b", o_fw, e); else passed++;
    regwm = 1'b1; rs1e = 5'd0;
    #1;
    e = exp_o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    total++; if (o_fw !== e) $display("FAIL fwd_x0: got %b expected %b", o_fw, e); else passed++;
    rs1e = 5'd9; rs2e = 5'd5; regwm = 1'b0;
    #1;
    e = exp_o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01);
    total++; if (o_fw !== e) $display("FAIL fwd_b_w: got %b expected %b", o_fw, e); else passed++;
    regwm = 1'b1;
    #1;
    e = exp_o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10);
    total++; if (o_fw !== e) $display("FAIL fwd_b_m: got %b expected %b", o_fw, e); else passed++;
  endtask

  task automatic test_load_use();
    logic [10:0] e;
    cyc();
    clear_inputs();
    lde = 1'b1; regwe = 1'b1; rde = 5'd7; rs2d = 5'd7;
    #1;
    e = exp_o(0, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    total++; if (o_fw !== e) $display("FAIL load_use_rs2: got %b expected %b", o_fw, e); else passed++;
    rs2d = 5'd0; rs1d = 5'd7;
    #1;
    total++; if (o_fw !== e) $display("FAIL load_use_rs1: got %b expected %b", o_fw, e); else passed++;
    rde = 5'd0; rs1d = 5'd0;
    #1;
    e = '0;
    total++; if (o_fw !== e) $display("FAIL load_use_x0: got %b expected %b", o_fw, e); else passed++;
    rde = 5'd7; rs1d = 5'd7; lde = 1'b0;
    #1;
    total++; if (o_fw !== e) $display("FAIL alu_use_forwarded: got %b expected %b", o_fw, e); else passed++;
  endtask

  task automatic test_multicycle();
    logic [4:0] e [4];
    e[0] = 5'b11111; e[1] = 5'b11111; e[2] = 5'b11111; e[3] = 5'b00000;
    cyc();
    clear_inputs();
    mce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      // A taken branch while BUSY must be ignored.
      pcse = (i == 1);
      #1;
      total++;
      if (mc_fw !== e[i]) $display("FAIL mc_cycle%0d: got %b expected %b", i + 1, mc_fw, e[i]);
      else passed++;
      if (i == 1) begin
        total++;
        if ({if_fw.FlushD, if_fw.FlushE} !== 2'b00)
          $display("FAIL mc_branch_ignored: got %b expected 00", {if_fw.FlushD, if_fw.FlushE});
        else passed++;
      end
    end
    total++; if (if_l1.BusyE !== 1'b0) $display("FAIL mc_latency1_busy: got %b expected 0", if_l1.BusyE); else passed++;
    cyc();
    mce = 1'b0; pcse = 1'b0;
    #1;
    total++; if (o_fw !== 11'd0) $display("FAIL mc_after_idle: got %b expected %b", o_fw, 11'd0); else passed++;
  endtask

  task automatic test_busy_exit_datastall();
    logic [10:0] e;
    cyc();
    clear_inputs();
    mce = 1'b1;
    cyc(); cyc(); cyc();
    // Final occupied cycle: MC interlock drops, load-use applies.
    lde = 1'b1; rde = 5'd4; rs1d = 5'd4;
    #1;
    e = exp_o(0, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    total++; if (o_fw !== e) $display("FAIL busy_exit_load_use: got %b expected %b", o_fw, e); else passed++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_branch_vs_mc();
    logic [10:0] e;
    cyc();
    clear_inputs();
    pcse = 1'b1; mce = 1'b1;
    #1;
    e = exp_o(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
    total++; if (o_fw !== e) $display("FAIL branch_over_mc: got %b expected %b", o_fw, e); else passed++;
    cyc();
    pcse = 1'b0; mce = 1'b0;
    #1;
    total++; if (if_fw.BusyE !== 1'b0) $display("FAIL branch_stays_idle: got %b expected 0", if_fw.BusyE); else passed++;
  endtask

  task automatic test_no_forward();
    logic [10:0] e;
    cyc();
    clear_inputs();
    regwm = 1'b1; rdm = 5'd3; rs1d = 5'd3; rs1e = 5'd3;
    #1;
    e = exp_o(0, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    total++; if (o_nf !== e) $display("FAIL nofwd_m_stall: got %b expected %b", o_nf, e); else passed++;
    e = exp_o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00);
    total++; if (o_fw !== e) $display("FAIL fwd_m_no_stall: got %b expected %b", o_fw, e); else passed++;
    regwm = 1'b0; regww = 1'b1; rdw = 5'd3;
    #1;
    total++; if (o_nf !== 11'd0) $display("FAIL nofwd_w_no_stall: got %b expected %b", o_nf, 11'd0); else passed++;
    regww = 1'b0; regwe = 1'b1; rde = 5'd3;
    #1;
    e = exp_o(0, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    total++; if (o_nf !== e) $display("FAIL nofwd_e_stall: got %b expected %b", o_nf, e); else passed++;
  endtask

  task automatic test_reset_mid_op();
    cyc();
    clear_inputs();
    mce = 1'b1;
    #1;
    total++; if (if_fw.BusyE !== 1'b1) $display("FAIL rmo_first_busy: got %b expected 1", if_fw.BusyE); else passed++;
    cyc();
    rst = 1'b1;
    #1;
    total++; if (o_fw !== 11'd0) $display("FAIL rmo_outputs_zero: got %b expected %b", o_fw, 11'd0); else passed++;
    cyc();
    rst = 1'b0; mce = 1'b0;
    #1;
    total++; if (if_fw.BusyE !== 1'b0) $display("FAIL rmo_after_release: got %b expected 0", if_fw.BusyE); else passed++;
    cyc();
    total++; if (if_fw.BusyE !== 1'b0) $display("FAIL rmo_still_idle: got %b expected 0", if_fw.BusyE); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_busy_exit_datastall();
    test_branch_vs_mc();
    test_no_forward();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W). Successor to the single-cycle hazard unit.
- Adds a configurable register-address width and a forwarding-disable mode, which falls back to interlock stalls.
- Adds a multi-cycle execute interlock: an L-cycle MUL/DIV occupancy FSM holds F/D/E and injects bubbles into M.
- Sits beside the datapath. Consumes stage register fields and drives the stall/flush enables and forwarding mux selects.

Parameters:
- REG_AW, 5, register address width (x0 is address 0).
- FORWARD_EN, 1, 1 = M/W forwarding to E; 0 = no forwarding, RAW hazards resolved by stalling in D.
- MC_LATENCY, 4, total cycles a multi-cycle op occupies E; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- Rs1D, Rs2D  in  REG_AW  source regs of the instruction in D
- Rs1E, Rs2E, RdE  in  REG_AW  source/dest regs in E
- RegWriteE  in  1  E instruction writes RdE
- ResultSrcE0  in  1  E instruction is a load
- MultiCycleE  in  1  E instruction is a multi-cycle op
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RegWriteM  in  REG_AW, 1  M-stage dest and write enable
- RdW, RegWriteW  in  REG_AW, 1  W-stage dest and write enable
- StallF, StallD, StallE  out  1  hold stage registers
- FlushD, FlushE, FlushM  out  1  clear stage registers (bubble)
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result
- BusyE  out  1  multi-cycle interlock active

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, cnt 0. While rst=1 all outputs are forced to 0. The first cycle after rst falls behaves as IDLE.
- Forwarding (combinational, FORWARD_EN=1):
  - ForwardAE=10 if RegWriteM & RdM==Rs1E & Rs1E!=0.
  - Else ForwardAE=01 if RegWriteW & RdW==Rs1E & Rs1E!=0.
  - Else ForwardAE=00. M has priority over W.
  - ForwardBE: same rule using Rs2E.
  - With FORWARD_EN=0, ForwardAE/ForwardBE are constant 00.
- Match helper: hitD(r) = (r!=0) & (r==Rs1D | r==Rs2D).
- dataStall:
  - FORWARD_EN=1: ResultSrcE0 & hitD(RdE).
  - FORWARD_EN=0: (RegWriteE & hitD(RdE)) | (RegWriteM & hitD(RdM)).
  - W needs no stall; the register file is write-first.
- FSM states IDLE and BUSY. Counter cnt is clog2(MC_LATENCY) bits wide, minimum 1 bit.
- IDLE, evaluated in priority order:
  1. PCSrcE=1: FlushD=1, FlushE=1, no stalls, MultiCycleE ignored, stay IDLE.
  2. MultiCycleE=1 and MC_LATENCY>1: StallF=StallD=StallE=1, FlushM=1, BusyE=1, dataStall ignored. Next state BUSY with cnt=MC_LATENCY-2.
  3. dataStall=1: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
  - With MC_LATENCY=1, MultiCycleE has no effect.
- BUSY:
  - MultiCycleE and PCSrcE are ignored.
  - If cnt!=0: StallF/D/E=1, FlushM=1, BusyE=1, cnt decrements.
  - If cnt==0: no MC stall; the op leaves E at this edge and the next state is IDLE. dataStall is evaluated and applied as in IDLE step 3.
- Timing: the op occupies E for exactly MC_LATENCY cycles. Exactly MC_LATENCY-1 cycles have BusyE=1.
- Forwarding stays active in all states.
- A rst pulse mid-BUSY returns the FSM to IDLE at that edge. The multi-cycle op is abandoned; the pipeline is flushed externally.

Test Plan:
- Forwarding priority, FORWARD_EN=1: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Clear RegWriteM -> 01. Rs1E=0 with all matches -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Change RdE=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: MultiCycleE held 1 for 4 cycles -> BusyE/StallF/StallD/StallE/FlushM = 1,1,1,0. On the 4th cycle BUSY is not re-entered despite MultiCycleE=1.
- Branch vs multi-cycle: IDLE with PCSrcE=1, MultiCycleE=1 -> FlushD=FlushE=1, BusyE=0, state stays IDLE.
- FORWARD_EN=0: RegWriteM=1, RdM=3, Rs1D=3 -> StallF=StallD=FlushE=1 and ForwardAE=00. RdW=3 only -> no stall.
- Reset mid-op: assert rst on the 2nd BusyE cycle -> all outputs 0 while rst=1. With MultiCycleE=0 after release, BusyE stays 0.
